// File: rtl/ws2811_serial_tx_if.sv
// ============================================================================
// Module : ws2811_serial_tx_if
// Brief  : Colour-source / strip-driver bundle for the WS2811 transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ws2811_serial_tx_if;
    logic        enable;
    logic [23:0] rgb;
    logic        dout;
    logic        advance;
    logic        serial_reset;
    logic        busy;

    modport master (
        output enable,
        output rgb,
        input  dout,
        input  advance,
        input  serial_reset,
        input  busy
    );

    modport slave (
        input  enable,
        input  rgb,
        output dout,
        output advance,
        output serial_reset,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/ws2811_serial_tx.sv
// ============================================================================
// Module : ws2811_serial_tx
// Brief  : Single-wire WS2811 NRZ transmitter with per-pixel advance strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ws2811_serial_tx #(
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int T_BIT    = 63,
    parameter int T_RESET  = 2500,
    parameter int NUM_LEDS = 50
) (
    input  wire logic        clock_i,
    input  wire logic        reset_i,
    ws2811_serial_tx_if.slave bus
);

    localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PIX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BIT  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(T_RESET - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_LEDS - 1);

    logic [1:0]       state_q, state_d;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       idx_q, idx_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             advance_q, advance_d;
    logic             load;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            pix_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            pix_q     <= pix_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            advance_q <= advance_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    load    = 1'b1;
                    pix_d   = '0;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (idx_q != 5'd0) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        idx_d   = idx_q - 5'd1;
                    end else if (pix_q != PIX_LAST) begin
                        // Next pixel loads with no idle cycle so bit timing stays seamless
                        load  = 1'b1;
                        pix_d = pix_q + PIX_W'(1);
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    pix_d = '0;
                    if (bus.enable) begin
                        load    = 1'b1;
                        state_d = S_BIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            shift_d = bus.rgb;
            idx_d   = 5'd23;
            cnt_d   = '0;
        end
    end

    // dout is registered, so it is derived from the next-state view of the datapath
    always_comb begin
        dout_d    = (state_d == S_BIT) &&
                    (cnt_d < (shift_d[23] ? CNT_W'(T1H) : CNT_W'(T0H)));
        advance_d = load;
    end

    assign bus.dout         = dout_q;
    assign bus.advance      = advance_q;
    assign bus.serial_reset = (state_q == S_GAP);
    assign bus.busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ws2811_serial_tx.sv
// ============================================================================
// Module : tb_ws2811_serial_tx
// Brief  : Scoreboard bench for ws2811_serial_tx (pulse widths, advance, gap).
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ws2811_serial_tx;

    localparam int P_T0H  = 2;
    localparam int P_T1H  = 4;
    localparam int P_TBIT = 6;
    localparam int P_TRST = 10;
    localparam int P_NLED = 2;
    localparam int FRAME  = P_NLED * 24 * P_TBIT + P_TRST;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2811_serial_tx_if bus_a ();
    ws2811_serial_tx_if bus_b ();

    ws2811_serial_tx #(.T0H(P_T0H), .T1H(P_T1H), .T_BIT(P_TBIT),
                       .T_RESET(P_TRST), .NUM_LEDS(P_NLED))
        u_dut_a (.clock_i(clk), .reset_i(rst), .bus(bus_a));

    ws2811_serial_tx #(.T0H(P_T0H), .T1H(P_T1H), .T_BIT(P_TBIT),
                       .T_RESET(1), .NUM_LEDS(1))
        u_dut_b (.clock_i(clk), .reset_i(rst), .bus(bus_b));

    int exp_w[$];
    int exp_adv[$];
    int exp_gap_len[$];
    int exp_gap_rise[$];
    int exp_adv_b[$];
    int exp_gap_b[$];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic bad_event(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d: got an event, expected none", name, cyc);
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d: got timeout, expected event", name, cyc);
    endtask

    // Frame starting at cycle k: widths MSB-first, one advance per pixel, one gap
    task automatic push_frame_a(input int k, input logic [23:0] c0, input logic [23:0] c1,
                                input int rise);
        for (int b = 23; b >= 0; b--) exp_w.push_back(c0[b] ? P_T1H : P_T0H);
        for (int b = 23; b >= 0; b--) exp_w.push_back(c1[b] ? P_T1H : P_T0H);
        exp_adv.push_back(k);
        exp_adv.push_back(k + 24 * P_TBIT);
        exp_gap_len.push_back(P_TRST);
        exp_gap_rise.push_back(rise);
    endtask

    task automatic wait_adv_a(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus_a.advance && n < 400);
        if (!bus_a.advance) timeout(name);
    endtask

    task automatic wait_adv_b(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus_b.advance && n < 400);
        if (!bus_b.advance) timeout(name);
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus_a.busy && n < 1200);
        if (bus_a.busy) timeout(name);
    endtask

    task automatic wait_idle_b(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus_b.busy && n < 400);
        if (bus_b.busy) timeout(name);
    endtask

    // Monitor for DUT A: pulse widths, bit period, advance cycles, gap length/exit
    initial begin
        logic pd = 1'b0;
        logic psr = 1'b0;
        int   run = 0;
        int   srun = 0;
        int   last_rise = 0;
        bit   lr_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_a.dout && !pd) begin
                if (lr_valid) chk("bit_period", cyc - last_rise, P_TBIT);
                last_rise = cyc;
                lr_valid  = 1'b1;
                run       = 1;
            end else if (bus_a.dout) begin
                run++;
            end else if (pd) begin
                if (exp_w.size() == 0) bad_event("pulse");
                else chk("pulse_width", run, exp_w.pop_front());
            end
            if (bus_a.serial_reset || !bus_a.busy) lr_valid = 1'b0;
            if (bus_a.advance) begin
                if (exp_adv.size() == 0) bad_event("advance");
                else chk("advance_cycle", cyc, exp_adv.pop_front());
            end
            if (bus_a.serial_reset) begin
                srun++;
            end else if (psr) begin
                if (exp_gap_len.size() == 0) begin
                    bad_event("gap");
                end else begin
                    chk("gap_length", srun, exp_gap_len.pop_front());
                    chk("gap_exit_dout", bus_a.dout, exp_gap_rise.pop_front());
                end
                srun = 0;
            end
            pd  = bus_a.dout;
            psr = bus_a.serial_reset;
        end
    end

    // Monitor for DUT B: advance spacing and single-cycle gap
    initial begin
        logic psr = 1'b0;
        int   srun = 0;
        forever begin
            @(negedge clk);
            if (bus_b.advance) begin
                if (exp_adv_b.size() == 0) bad_event("b_advance");
                else chk("b_advance_cycle", cyc, exp_adv_b.pop_front());
            end
            if (bus_b.serial_reset) begin
                srun++;
            end else if (psr) begin
                if (exp_gap_b.size() == 0) begin
                    bad_event("b_gap");
                end else begin
                    chk("b_gap_length", srun, 1);
                    chk("b_gap_exit_dout", bus_b.dout, exp_gap_b.pop_front());
                end
                srun = 0;
            end
            psr = bus_b.serial_reset;
        end
    end

    initial begin
        int k;
        bus_a.enable = 1'b0;
        bus_a.rgb    = '0;
        bus_b.enable = 1'b0;
        bus_b.rgb    = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dout", bus_a.dout, 0);
        chk("reset_advance", bus_a.advance, 0);
        chk("reset_serial_reset", bus_a.serial_reset, 0);
        chk("reset_busy", bus_a.busy, 0);
        chk("reset_busy_b", bus_b.busy, 0);
        rst = 1'b0;

        // Single frame, one-cycle enable, A50000 then black
        @(negedge clk);
        bus_a.rgb    = 24'hA50000;
        bus_a.enable = 1'b1;
        k = cyc + 1;
        push_frame_a(k, 24'hA50000, 24'h000000, 0);
        wait_adv_a("t1_adv0");
        chk("start_busy", bus_a.busy, 1);
        chk("start_dout", bus_a.dout, 1);
        bus_a.enable = 1'b0;
        bus_a.rgb    = 24'h000000;
        wait_idle_a("t1_idle");
        chk("t1_idle_cycle", cyc, k + FRAME);
        chk("t1_idle_dout", bus_a.dout, 0);
        chk("t1_idle_sr", bus_a.serial_reset, 0);

        // Three back-to-back frames, colour flips on each advance, enable dropped mid frame 3
        @(negedge clk);
        bus_a.rgb    = 24'hFFFFFF;
        bus_a.enable = 1'b1;
        k = cyc + 1;
        push_frame_a(k, 24'hFFFFFF, 24'h000000, 1);
        push_frame_a(k + FRAME, 24'hFFFFFF, 24'h000000, 1);
        push_frame_a(k + 2 * FRAME, 24'hFFFFFF, 24'h000000, 0);
        for (int i = 0; i < 5; i++) begin
            wait_adv_a("t3_adv");
            bus_a.rgb = ~bus_a.rgb;
        end
        bus_a.enable = 1'b0;
        wait_idle_a("t5_idle");
        chk("t5_idle_cycle", cyc, k + 3 * FRAME);

        // Abort with reset during bit 8 of a frame
        @(negedge clk);
        bus_a.rgb    = 24'h123456;
        bus_a.enable = 1'b1;
        k = cyc + 1;
        exp_adv.push_back(k);
        for (int b = 23; b >= 15; b--) exp_w.push_back(bus_a.rgb[b] ? P_T1H : P_T0H);
        @(negedge clk);
        bus_a.enable = 1'b0;
        repeat (49) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_dout", bus_a.dout, 0);
        chk("abort_busy", bus_a.busy, 0);
        chk("abort_sr", bus_a.serial_reset, 0);
        chk("abort_advance", bus_a.advance, 0);
        rst = 1'b0;

        // Restart after abort begins again at pixel 0, bit 23
        @(negedge clk);
        bus_a.rgb    = 24'hA50000;
        bus_a.enable = 1'b1;
        k = cyc + 1;
        push_frame_a(k, 24'hA50000, 24'hA50000, 0);
        @(negedge clk);
        bus_a.enable = 1'b0;
        wait_idle_a("t4_idle");

        // Single pixel, single gap cycle, continuous enable
        @(negedge clk);
        bus_b.rgb    = 24'h800001;
        bus_b.enable = 1'b1;
        k = cyc + 1;
        exp_adv_b.push_back(k);
        exp_adv_b.push_back(k + 145);
        exp_adv_b.push_back(k + 290);
        exp_gap_b.push_back(1);
        exp_gap_b.push_back(1);
        exp_gap_b.push_back(0);
        repeat (3) wait_adv_b("t6_adv");
        bus_b.enable = 1'b0;
        wait_idle_b("t6_idle");
        repeat (4) @(negedge clk);

        chk("left_pulses", exp_w.size(), 0);
        chk("left_advance", exp_adv.size(), 0);
        chk("left_gaps", exp_gap_len.size(), 0);
        chk("left_advance_b", exp_adv_b.size(), 0);
        chk("left_gaps_b", exp_gap_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
